// File: rtl/sm_timebase_divider_if.sv
// Bus bundle for sm_timebase_divider: CPU-side controls in, time-base status out.
// Preset ports exist only when SM_DIVIDER_PRESET_EN is defined.
interface sm_timebase_divider_if #(
  parameter int DIV_WIDTH  = 15,
  parameter int NUM_TAPS   = 4,
  parameter int PEND_WIDTH = 2
);
  logic                  clk_en;
  logic [3:0]            cpu_id;
  logic                  reset_gamma;
  logic                  reset_divider;
  logic                  wrap_ack;
`ifdef SM_DIVIDER_PRESET_EN
  logic                  preset_valid;
  logic [DIV_WIDTH-1:0]  preset_value;
`endif
  logic                  gamma;
  logic                  wrap_tick;
  logic [PEND_WIDTH-1:0] wrap_pending;
  logic [NUM_TAPS-1:0]   tap_level;
  logic [NUM_TAPS-1:0]   tap_rise;
  logic [DIV_WIDTH-1:0]  count;

  modport master (
    output clk_en, cpu_id, reset_gamma, reset_divider, wrap_ack,
`ifdef SM_DIVIDER_PRESET_EN
    output preset_valid, preset_value,
`endif
    input  gamma, wrap_tick, wrap_pending, tap_level, tap_rise, count
  );

  modport slave (
    input  clk_en, cpu_id, reset_gamma, reset_divider, wrap_ack,
`ifdef SM_DIVIDER_PRESET_EN
    input  preset_valid, preset_value,
`endif
    output gamma, wrap_tick, wrap_pending, tap_level, tap_rise, count
  );
endinterface

// File: rtl/sm_timebase_divider.sv
// SM5xx free-running time base: prescaler, level/edge taps, wrap tick, gamma flag and
// saturating pending-wrap count. Define SM_DIVIDER_PRESET_EN to add the preset load port.
module sm_timebase_divider #(
  parameter int                      DIV_WIDTH       = 15,
  parameter int                      NUM_TAPS        = 4,
  parameter logic [4*NUM_TAPS-1:0]   TAP_BITS        = {4'd14, 4'd11, 4'd10, 4'd4},
  parameter int                      DIV_RELOAD      = 2,
  parameter logic [15:0]             GAMMA_INIT_MASK = 16'h0010,
  parameter int                      PEND_WIDTH      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  sm_timebase_divider_if.slave bus
);

  logic [DIV_WIDTH-1:0]  count_q, count_nx, count_inc;
  logic                  gamma_q, gamma_nx;
  logic                  wrap_q, wrap;
  logic [NUM_TAPS-1:0]   rise_q, rise_nx, level;
  logic [PEND_WIDTH-1:0] pend_q, pend_nx;
  logic                  load_preset;
  logic                  inc;
  logic [3:0]            tap_idx;
  logic [DIV_WIDTH-1:0]  cur_sh, inc_sh;

`ifdef SM_DIVIDER_PRESET_EN
  assign load_preset = bus.preset_valid;
`else
  assign load_preset = 1'b0;
`endif

  always_comb begin
    count_inc = count_q + DIV_WIDTH'(1);
    inc       = bus.clk_en && !bus.reset_divider && !load_preset;
    wrap      = inc && (count_q == '1);
    rise_nx   = '0;
    level     = '0;
    tap_idx   = '0;
    cur_sh    = '0;
    inc_sh    = '0;
    // Shift instead of indexing so the tap index width need not match DIV_WIDTH.
    for (int unsigned i = 0; i < NUM_TAPS; i++) begin
      tap_idx    = TAP_BITS[4*i +: 4];
      cur_sh     = count_q >> tap_idx;
      inc_sh     = count_inc >> tap_idx;
      level[i]   = cur_sh[0];
      rise_nx[i] = inc && !cur_sh[0] && inc_sh[0];
    end
  end

  always_comb begin
    count_nx = count_q;
`ifdef SM_DIVIDER_PRESET_EN
    if (load_preset)
      count_nx = bus.preset_value;
    else
`endif
    if (bus.clk_en)
      count_nx = bus.reset_divider ? DIV_WIDTH'(DIV_RELOAD) : count_inc;

    gamma_nx = gamma_q;
    if (bus.clk_en && bus.reset_gamma)
      gamma_nx = 1'b0;
    if (wrap)
      gamma_nx = 1'b1;

    pend_nx = pend_q;
    if (wrap && !bus.wrap_ack) begin
      if (pend_q != '1)
        pend_nx = pend_q + PEND_WIDTH'(1);
    end else if (!wrap && bus.wrap_ack) begin
      if (pend_q != '0)
        pend_nx = pend_q - PEND_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      gamma_q <= GAMMA_INIT_MASK[bus.cpu_id];
      wrap_q  <= 1'b0;
      rise_q  <= '0;
      pend_q  <= '0;
    end else begin
      count_q <= count_nx;
      gamma_q <= gamma_nx;
      wrap_q  <= wrap;
      rise_q  <= rise_nx;
      pend_q  <= pend_nx;
    end
  end

  assign bus.count        = count_q;
  assign bus.gamma        = gamma_q;
  assign bus.wrap_tick    = wrap_q;
  assign bus.tap_rise     = rise_q;
  assign bus.wrap_pending = pend_q;
  assign bus.tap_level    = level;

endmodule

// File: tb/tb_sm_timebase_divider.sv
// Bench for sm_timebase_divider: a full-width instance and a 5-bit instance, both checked
// every cycle against an arithmetic model, plus directed literal checks.
module tb_sm_timebase_divider;

  localparam int          BW     = 15;
  localparam int          SW     = 5;
  localparam logic [15:0] B_TAPS = {4'd14, 4'd11, 4'd10, 4'd4};
  localparam logic [15:0] S_TAPS = 16'h4310;
  localparam logic [15:0] GMASK  = 16'h0010;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sm_timebase_divider_if #(.DIV_WIDTH(BW), .NUM_TAPS(4), .PEND_WIDTH(2)) bb ();
  sm_timebase_divider_if #(.DIV_WIDTH(SW), .NUM_TAPS(4), .PEND_WIDTH(2)) sb ();

  sm_timebase_divider dut_b (.clk(clk), .reset(reset), .bus(bb));
  sm_timebase_divider #(
    .DIV_WIDTH(SW), .NUM_TAPS(4), .TAP_BITS(S_TAPS), .DIV_RELOAD(2),
    .GAMMA_INIT_MASK(GMASK), .PEND_WIDTH(2)
  ) dut_s (.clk(clk), .reset(reset), .bus(sb));

  typedef struct {
    int       count;
    bit       gamma;
    int       pend;
    bit       wrap;
    bit [3:0] rise;
  } mstate_t;

  mstate_t mb, ms;
  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;
  int  rise_b = 0;

  function automatic mstate_t mstep(mstate_t s, int w, logic [15:0] taps, bit rst, int cid,
                                    bit en, bit rg, bit rd, bit ack, bit pv, int pval);
    mstate_t n;
    int modv;
    int b;
    n      = s;
    n.wrap = 1'b0;
    n.rise = '0;
    modv   = 1 << w;
    if (rst) begin
      n.count = 0;
      n.gamma = ((GMASK >> cid) & 16'd1) != 0;
      n.pend  = 0;
      return n;
    end
    if (pv) n.count = pval;
    else if (en) begin
      if (rd) n.count = 2;
      else begin
        n.count = (s.count + 1) % modv;
        n.wrap  = (s.count == modv - 1);
        for (int i = 0; i < 4; i++) begin
          b = int'((taps >> (4*i)) & 16'hF);
          n.rise[i] = (((s.count >> b) & 1) == 0) && (((n.count >> b) & 1) == 1);
        end
      end
    end
    if (en && rg) n.gamma = 1'b0;
    if (n.wrap)   n.gamma = 1'b1;
    if (n.wrap && !ack)      n.pend = (s.pend < 3) ? s.pend + 1 : 3;
    else if (ack && !n.wrap) n.pend = (s.pend > 0) ? s.pend - 1 : 0;
    return n;
  endfunction

  function automatic int mlevel(int c, logic [15:0] taps);
    int r;
    int b;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      b = int'((taps >> (4*i)) & 16'hF);
      r = r | (((c >> b) & 1) << i);
    end
    return r;
  endfunction

  always @(posedge clk) begin
`ifdef SM_DIVIDER_PRESET_EN
    mb <= mstep(mb, BW, B_TAPS, reset, int'(bb.cpu_id), bb.clk_en, bb.reset_gamma,
                bb.reset_divider, bb.wrap_ack, bb.preset_valid, int'(bb.preset_value));
    ms <= mstep(ms, SW, S_TAPS, reset, int'(sb.cpu_id), sb.clk_en, sb.reset_gamma,
                sb.reset_divider, sb.wrap_ack, sb.preset_valid, int'(sb.preset_value));
`else
    mb <= mstep(mb, BW, B_TAPS, reset, int'(bb.cpu_id), bb.clk_en, bb.reset_gamma,
                bb.reset_divider, bb.wrap_ack, 1'b0, 0);
    ms <= mstep(ms, SW, S_TAPS, reset, int'(sb.cpu_id), sb.clk_en, sb.reset_gamma,
                sb.reset_divider, sb.wrap_ack, 1'b0, 0);
`endif
  end

  task automatic cmp(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("b.count",     int'(bb.count),        mb.count);
      cmp("b.gamma",     int'(bb.gamma),        int'(mb.gamma));
      cmp("b.wrap_tick", int'(bb.wrap_tick),    int'(mb.wrap));
      cmp("b.pending",   int'(bb.wrap_pending), mb.pend);
      cmp("b.tap_level", int'(bb.tap_level),    mlevel(mb.count, B_TAPS));
      cmp("b.tap_rise",  int'(bb.tap_rise),     int'(mb.rise));
      cmp("s.count",     int'(sb.count),        ms.count);
      cmp("s.gamma",     int'(sb.gamma),        int'(ms.gamma));
      cmp("s.wrap_tick", int'(sb.wrap_tick),    int'(ms.wrap));
      cmp("s.pending",   int'(sb.wrap_pending), ms.pend);
      cmp("s.tap_level", int'(sb.tap_level),    mlevel(ms.count, S_TAPS));
      cmp("s.tap_rise",  int'(sb.tap_rise),     int'(ms.rise));
      if (bb.tap_rise[0]) rise_b++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int r0;
    bb.clk_en = 0; bb.cpu_id = 4'd4; bb.reset_gamma = 0; bb.reset_divider = 0; bb.wrap_ack = 0;
    sb.clk_en = 0; sb.cpu_id = 4'd0; sb.reset_gamma = 0; sb.reset_divider = 0; sb.wrap_ack = 0;
`ifdef SM_DIVIDER_PRESET_EN
    bb.preset_valid = 0; bb.preset_value = '0;
    sb.preset_valid = 0; sb.preset_value = '0;
`endif
    reset = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    cmp("lit reset gamma cpu4", int'(bb.gamma), 1);
    cmp("lit reset count", int'(bb.count), 0);
    cmp("lit reset pending", int'(bb.wrap_pending), 0);
    cmp("lit reset gamma cpu0", int'(sb.gamma), 0);
    bb.cpu_id = 4'd0;
    cyc();
    cmp("lit reset gamma cpu0 big", int'(bb.gamma), 0);
    reset = 1'b0;

    // Small instance: reset_gamma vs wrap, reset_divider at all-ones, saturation, acks.
    sb.clk_en = 1;
    repeat (31) cyc();
    cmp("lit s count 31", int'(sb.count), 31);
    sb.reset_gamma = 1;
    cyc();
    sb.reset_gamma = 0;
    cmp("lit wrap beats reset_gamma", int'(sb.gamma), 1);
    cmp("lit wrap tick", int'(sb.wrap_tick), 1);
    cmp("lit pending 1", int'(sb.wrap_pending), 1);
    repeat (31) cyc();
    sb.reset_divider = 1;
    cyc();
    sb.reset_divider = 0;
    cmp("lit reload count", int'(sb.count), 2);
    cmp("lit reload no tick", int'(sb.wrap_tick), 0);
    cmp("lit reload pending", int'(sb.wrap_pending), 1);
    repeat (30) cyc();
    cmp("lit pending 2", int'(sb.wrap_pending), 2);
    repeat (64) cyc();
    cmp("lit pending saturated", int'(sb.wrap_pending), 3);
    repeat (31) cyc();
    sb.wrap_ack = 1;
    cyc();
    cmp("lit wrap+ack tick", int'(sb.wrap_tick), 1);
    cmp("lit wrap+ack pending", int'(sb.wrap_pending), 3);
    sb.clk_en = 0;
    repeat (4) cyc();
    cmp("lit four acks", int'(sb.wrap_pending), 0);
    cyc();
    cmp("lit ack at zero", int'(sb.wrap_pending), 0);
    sb.wrap_ack = 0;
    sb.reset_gamma = 1;
    cyc();
    sb.reset_gamma = 0;
    cmp("lit reset_gamma ignored", int'(sb.gamma), 1);
    for (int i = 0; i < 200; i++) begin
      sb.clk_en = (i % 4 == 0);
      cyc();
    end
    sb.clk_en = 0;
    cmp("lit 1-of-4 count", int'(sb.count), 18);

    fork
      begin
        bb.clk_en = 1;
        r0 = rise_b;
        repeat (32768) cyc();
        bb.clk_en = 0;
        cmp("lit full wrap count", int'(bb.count), 0);
        cmp("lit full wrap tick", int'(bb.wrap_tick), 1);
        cmp("lit full wrap gamma", int'(bb.gamma), 1);
        cmp("lit full wrap pending", int'(bb.wrap_pending), 1);
        cmp("lit bit4 rises", rise_b - r0, 1024);
      end
      begin
        repeat (32768) begin
          sb.clk_en        = ($urandom_range(0, 1) == 1);
          sb.reset_gamma   = ($urandom_range(0, 7) == 0);
          sb.reset_divider = ($urandom_range(0, 15) == 0);
          sb.wrap_ack      = ($urandom_range(0, 3) == 0);
`ifdef SM_DIVIDER_PRESET_EN
          sb.preset_valid  = ($urandom_range(0, 31) == 0);
          sb.preset_value  = SW'($urandom_range(0, 31));
`endif
          cyc();
        end
        sb.clk_en = 0; sb.reset_gamma = 0; sb.reset_divider = 0; sb.wrap_ack = 0;
`ifdef SM_DIVIDER_PRESET_EN
        sb.preset_valid = 0;
`endif
      end
    join
    cyc();

`ifdef SM_DIVIDER_PRESET_EN
    bb.preset_value = 15'h7FFE;
    bb.preset_valid = 1;
    cyc();
    bb.preset_valid = 0;
    cmp("lit preset count", int'(bb.count), 32766);
    cmp("lit preset no tick", int'(bb.wrap_tick), 0);
    cmp("lit preset no rise", int'(bb.tap_rise), 0);
    bb.clk_en = 1;
    cyc();
    cyc();
    cmp("lit preset wrap tick", int'(bb.wrap_tick), 1);
    bb.preset_valid = 1;
    cyc();
    bb.preset_valid = 0;
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    bb.clk_en = 0;
    cmp("lit reset mid count", int'(bb.count), 0);
    cmp("lit reset mid tick", int'(bb.wrap_tick), 0);
    cmp("lit reset mid rise", int'(bb.tap_rise), 0);
    cyc();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
